// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 permutation tables, rotate schedule, widths and
// the key-schedule state enum. Also used by the DES round core.
package des_pkg;

   localparam int KEY_W    = 64;
   localparam int HALF_W   = 28;
   localparam int CD_W     = 2 * HALF_W;
   localparam int SUBKEY_W = 48;
   localparam int ROUNDS   = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Tables hold 1-based DES bit numbers; DES bit 1 is the MSB of the vector.
   localparam int PC1_TABLE [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TABLE [SUBKEY_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam int SHIFT_TABLE [ROUNDS] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
      logic [CD_W-1:0] cd;
      logic [5:0]      src;
      cd = '0;
      for (int j = 0; j < CD_W; j++) begin
         src = 6'(KEY_W - PC1_TABLE[j]);
         cd[6'(CD_W - 1 - j)] = key[src];
      end
      return cd;
   endfunction

   function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int amt);
      return (amt == 2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                        : {x[HALF_W-2:0], x[HALF_W-1]};
   endfunction

   function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input int amt);
      return (amt == 2) ? {x[1:0], x[HALF_W-1:2]}
                        : {x[0], x[HALF_W-1:1]};
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Purely combinational PC-2 compression of the 56-bit C||D register pair into a
// 48-bit round subkey (PC-2 bit 1 lands on subkey[47]).
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0]     cd,
   output logic [SUBKEY_W-1:0] subkey
);

   logic [5:0] src;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      subkey = '0;
      src    = '0;
      for (int j = 0; j < SUBKEY_W; j++) begin
         src = 6'(CD_W - PC2_TABLE[j]);
         subkey[6'(SUBKEY_W - 1 - j)] = cd[src];
      end
   end

   // Eight C/D bits never reach a subkey; folding them here keeps them visibly consumed.
   logic unused_dropped;
   assign unused_dropped = ^cd;

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 48-bit subkey per advance, K1..K16 (or K16..K1
// when built with DES_KEY_DECRYPT_EN and decrypt=1 at load).
module des_key_schedule
   import des_pkg::*;
#(
   parameter bit AUTO_ADVANCE = 1'b0
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [KEY_W-1:0]    key_in,
   input  logic                load,
`ifdef DES_KEY_DECRYPT_EN
   input  logic                decrypt,
`endif
   input  logic                next,
   output logic [SUBKEY_W-1:0] subkey_out,
   output logic [3:0]          round_out,
   output logic                subkey_valid,
   output logic                busy,
   output logic                done
);

   state_t                state, state_next;
   logic [HALF_W-1:0]     c, d, c_next, d_next;
   logic [3:0]            round_next;
   logic                  valid_next, done_next, subkey_en;
   logic                  decrypt_mode, decrypt_mode_next;
   logic                  load_decrypt, advance;
   logic [CD_W-1:0]       cd_load;
   logic [SUBKEY_W-1:0]   pc2_out;

`ifdef DES_KEY_DECRYPT_EN
   assign load_decrypt = decrypt;
`else
   assign load_decrypt = 1'b0;
`endif

   assign cd_load = pc1(key_in);
   assign advance = subkey_valid && (next || AUTO_ADVANCE);
   assign busy    = (state == RUN);

   // Parity bits are dropped by PC-1; the reduction marks them as intentionally unused.
   logic unused_parity;
   assign unused_parity = ^key_in;

   always_comb begin
      state_next        = state;
      c_next            = c;
      d_next            = d;
      round_next        = round_out;
      valid_next        = subkey_valid;
      done_next         = 1'b0;
      subkey_en         = 1'b0;
      decrypt_mode_next = decrypt_mode;
      case (state)
         IDLE: begin
            if (load) begin
               state_next        = RUN;
               valid_next        = 1'b1;
               round_next        = 4'd0;
               subkey_en         = 1'b1;
               decrypt_mode_next = load_decrypt;
               if (load_decrypt) begin
                  c_next = cd_load[CD_W-1:HALF_W];
                  d_next = cd_load[HALF_W-1:0];
               end else begin
                  c_next = rotl(cd_load[CD_W-1:HALF_W], SHIFT_TABLE[0]);
                  d_next = rotl(cd_load[HALF_W-1:0], SHIFT_TABLE[0]);
               end
            end
         end
         RUN: begin
            if (advance) begin
               if (round_out == 4'd15) begin
                  state_next = IDLE;
                  valid_next = 1'b0;
                  round_next = 4'd0;
                  done_next  = 1'b1;
               end else begin
                  round_next = round_out + 4'd1;
                  subkey_en  = 1'b1;
                  // Decrypt walks the schedule backwards, undoing the shift that produced the current key.
                  if (decrypt_mode) begin
                     c_next = rotr(c, SHIFT_TABLE[4'd15 - round_out]);
                     d_next = rotr(d, SHIFT_TABLE[4'd15 - round_out]);
                  end else begin
                     c_next = rotl(c, SHIFT_TABLE[round_out + 4'd1]);
                     d_next = rotl(d, SHIFT_TABLE[round_out + 4'd1]);
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   des_pc2 u_pc2 (
      .cd     ({c_next, d_next}),
      .subkey (pc2_out)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         c            <= '0;
         d            <= '0;
         round_out    <= '0;
         subkey_out   <= '0;
         subkey_valid <= 1'b0;
         done         <= 1'b0;
         decrypt_mode <= 1'b0;
      end else begin
         state        <= state_next;
         c            <= c_next;
         d            <= d_next;
         round_out    <= round_next;
         subkey_valid <= valid_next;
         done         <= done_next;
         decrypt_mode <= decrypt_mode_next;
         if (subkey_en) begin
            subkey_out <= pc2_out;
         end
      end
   end

endmodule
